// File: rtl/rf_wb_arbiter_if.sv
// Writeback request bus between NREQ result producers and rf_wb_arbiter.
// Handshake: a requester raises req_valid[i] and holds req_waddr/req_wdata
// slice i stable until req_ready[i] is seen high; the transfer happens on the
// clock edge where req_valid[i] & req_ready[i] are both 1. req_ready is a
// combinational one-hot grant and may depend on req_valid in the same cycle.
interface rf_wb_arbiter_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]    req_valid;
   logic [5*NREQ-1:0]  req_waddr;
   logic [32*NREQ-1:0] req_wdata;
   logic [NREQ-1:0]    req_ready;

   modport master (
      output req_valid,
      output req_waddr,
      output req_wdata,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_waddr,
      input  req_wdata,
      output req_ready
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin arbiter sharing the single regfile write port
// among NREQ writeback sources (0 = ALU, 1 = LSU, 2 = MDU), with a registered
// write stage and a 32-entry pending-write bitmap for decode stalls.
// Optional feature macro: RF_WB_FWD_EN adds fwd_valid/fwd_addr/fwd_data and
// makes busy drop combinationally for the register being written this cycle.
module rf_wb_arbiter #(
   parameter int NREQ = 3
) (
   input  logic          clk,
   input  logic          reset,
   rf_wb_arbiter_if.slave wb,
   input  logic          issue_valid,
   input  logic [4:0]    issue_addr,
   output logic          rf_we,
   output logic [4:0]    rf_waddr,
   output logic [31:0]   rf_wdata,
   output logic [31:0]   busy
`ifdef RF_WB_FWD_EN
   ,
   output logic          fwd_valid,
   output logic [4:0]    fwd_addr,
   output logic [31:0]   fwd_data
`endif
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   gnt_idx;
   logic [NREQ-1:0] grant;
   logic            found;
   logic            fire;
   logic [4:0]      sel_addr;
   logic [31:0]     sel_data;
   logic [31:0]     busy_q;
   logic [31:0]     set_vec;
   logic [31:0]     clr_vec;

   // Round-robin search: first pass covers rr_ptr..NREQ-1, second pass wraps
   // to 0..rr_ptr-1, so no modular arithmetic is needed on the index.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && (PW'(i) >= rr_ptr) && wb.req_valid[i]) begin
            grant[i] = 1'b1;
            gnt_idx  = PW'(i);
            found    = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && (PW'(i) < rr_ptr) && wb.req_valid[i]) begin
            grant[i] = 1'b1;
            gnt_idx  = PW'(i);
            found    = 1'b1;
         end
      end
   end

   assign wb.req_ready = reset ? '0 : grant;
   assign fire         = found && !reset;

   // Select the granted requester's destination and result.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_addr = wb.req_waddr[5*i +: 5];
            sel_data = wb.req_wdata[32*i +: 32];
         end
      end
   end

   // Pointer moves just past the winner, wrapping explicitly for any NREQ.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (fire) begin
         rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
      end
   end

   // Registered write stage: one-cycle we pulse per grant, GR0 never written.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (fire) begin
         rf_we    <= (sel_addr != 5'd0);
         rf_waddr <= sel_addr;
         rf_wdata <= sel_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

   // Per-register set (new producer issued) and clear (write committing) masks.
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (issue_valid) set_vec[issue_addr] = 1'b1;
      if (rf_we)       clr_vec[rf_waddr]   = 1'b1;
      set_vec[0] = 1'b0;
      clr_vec[0] = 1'b0;
   end

   // Pending bitmap; a same-edge set overrides the clear of an older write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= set_vec | (busy_q & ~clr_vec);
      end
   end

`ifdef RF_WB_FWD_EN
   assign fwd_valid = rf_we;
   assign fwd_addr  = rf_waddr;
   assign fwd_data  = rf_wdata;
   assign busy      = busy_q & ~(clr_vec & ~set_vec);
`else
   assign busy      = busy_q;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vectors push expected grants and writes
// into queues; a negedge monitor pops and compares whenever the DUT presents
// a grant or a regfile write.
module tb_rf_wb_arbiter;

   logic        clk;
   logic        reset;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] busy;
`ifdef RF_WB_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [31:0] fwd_data;
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   logic [2:0]  gnt_q[$];
   logic [36:0] exp_q[$];

   rf_wb_arbiter_if #(.NREQ(3)) wb();

   rf_wb_arbiter #(.NREQ(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .wb          (wb),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .rf_we       (rf_we),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata),
      .busy        (busy)
`ifdef RF_WB_FWD_EN
      ,
      .fwd_valid   (fwd_valid),
      .fwd_addr    (fwd_addr),
      .fwd_data    (fwd_data)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // driver: apply one cycle of stimulus and queue the expected responses
   task automatic step(input logic [2:0] v,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic iv, input logic [4:0] ia, input logic [2:0] eg);
      wb.req_valid = v;
      wb.req_waddr = {a2, a1, a0};
      wb.req_wdata = {d2, d1, d0};
      issue_valid  = iv;
      issue_addr   = ia;
      if (v != 3'b000) gnt_q.push_back(eg);
      if (eg[0] && a0 != 5'd0) exp_q.push_back({a0, d0});
      if (eg[1] && a1 != 5'd0) exp_q.push_back({a1, d1});
      if (eg[2] && a2 != 5'd0) exp_q.push_back({a2, d2});
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic iv, input logic [4:0] ia);
      step(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, iv, ia, 3'b000);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (wb.req_valid != 3'b000) begin
            checks++;
            if (gnt_q.size() == 0) begin
               errors++;
               $display("FAIL grant_unexpected actual=%b required=none", wb.req_ready);
            end else begin
               logic [2:0] eg;
               eg = gnt_q.pop_front();
               if (wb.req_ready !== eg) begin
                  errors++;
                  $display("FAIL grant actual=%b required=%b", wb.req_ready, eg);
               end
            end
         end else begin
            checks++;
            if (wb.req_ready !== 3'b000) begin
               errors++;
               $display("FAIL grant_idle actual=%b required=000", wb.req_ready);
            end
         end
         if (rf_we) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL write_unexpected actual=%0h/%h required=none", rf_waddr, rf_wdata);
            end else begin
               logic [36:0] ew;
               ew = exp_q.pop_front();
               if ({rf_waddr, rf_wdata} !== ew) begin
                  errors++;
                  $display("FAIL write actual=%0h/%h required=%0h/%h",
                           rf_waddr, rf_wdata, ew[36:32], ew[31:0]);
               end
            end
         end
      end
   end

   initial begin
      reset        = 1'b1;
      issue_valid  = 1'b0;
      issue_addr   = '0;
      wb.req_valid = 3'b111;
      wb.req_waddr = '0;
      wb.req_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_we",    {63'd0, rf_we}, 64'd0);
      chk("reset_waddr", {59'd0, rf_waddr}, 64'd0);
      chk("reset_wdata", {32'd0, rf_wdata}, 64'd0);
      chk("reset_busy",  {32'd0, busy}, 64'd0);
      chk("reset_ready", {61'd0, wb.req_ready}, 64'd0);
      wb.req_valid = 3'b000;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // single requester: grant same cycle, write next cycle
      step(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001);
      idle(1'b0, 5'd0);

      // reset in the middle of a write (rr now 1, so req1 wins)
      step(3'b010, 5'd0, 5'd3, 5'd0, 32'd0, 32'h0000_0333, 32'd0, 1'b1, 5'd9, 3'b010);
      chk("midwr_we_pre", {63'd0, rf_we}, 64'd1);
      wb.req_valid = 3'b000;
      issue_valid  = 1'b0;
      reset        = 1'b1;
      exp_q.delete();
      #1;
      chk("midwr_we",   {63'd0, rf_we}, 64'd0);
      chk("midwr_busy", {32'd0, busy}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // round-robin from pointer 0 with all three held valid
      for (int k = 0; k < 6; k++) begin
         logic [2:0] eg;
         eg = 3'b001 << (k % 3);
         step(3'b111, 5'd10, 5'd11, 5'd12, 32'h1000_000A, 32'h2000_000B, 32'h3000_000C,
              1'b0, 5'd0, eg);
      end
      idle(1'b0, 5'd0);

      // GR0 write: handshake completes, no regfile write, busy unchanged
      step(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'h5555_5555, 32'd0, 1'b1, 5'd4, 3'b010);
      idle(1'b0, 5'd0);
      chk("gr0_busy", {32'd0, busy}, 64'h10);

      // scoreboard set / clear / set-wins
      idle(1'b1, 5'd7);
      chk("sb_set7", {32'd0, busy}, 64'h90);
      step(3'b100, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h77, 1'b0, 5'd0, 3'b100);
      chk("sb_commit_cycle", {32'd0, busy}, FWD ? 64'h10 : 64'h90);
      idle(1'b0, 5'd0);
      chk("sb_clr7", {32'd0, busy}, 64'h10);
      step(3'b100, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 32'h88, 1'b0, 5'd0, 3'b100);
      idle(1'b1, 5'd7);
      chk("sb_setwins7", {32'd0, busy}, 64'h90);

      // write to 9 with bypass visibility
      idle(1'b1, 5'd9);
      chk("sb_set9", {32'd0, busy}, 64'h290);
      step(3'b001, 5'd9, 5'd0, 5'd0, 32'h1234, 32'd0, 32'd0, 1'b0, 5'd0, 3'b001);
`ifdef RF_WB_FWD_EN
      chk("fwd_valid", {63'd0, fwd_valid}, 64'd1);
      chk("fwd_addr",  {59'd0, fwd_addr}, 64'd9);
      chk("fwd_data",  {32'd0, fwd_data}, 64'h1234);
`endif
      chk("wr9_busy", {32'd0, busy}, FWD ? 64'h090 : 64'h290);
      idle(1'b0, 5'd0);
      chk("wr9_busy_after", {32'd0, busy}, 64'h090);
      idle(1'b0, 5'd0);

      chk("gnt_q_empty", 64'(gnt_q.size()), 64'd0);
      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
